// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and default constants for the single-step / run-rate controller.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_HALTED = 2'd2
  } step_mode_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned RUN_DIV_DEF         = 500_000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 25_000_000;
  localparam int unsigned COUNT_W_DEF         = 16;

  // Width of a counter that must hold 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Push-button synchroniser, debounce counter and press-pulse generator.
module step_debounce
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic button_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic            stable_n;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      stable_n <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_n};
      press  <= 1'b0;
      if (clear) begin
        // Track the value sync_q[1] takes at this edge, so a button held
        // through reset is already stable when clear drops.
        stable_n <= sync_q[0];
        db_cnt   <= '0;
      end else if (sync_q[1] == stable_n) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_n <= sync_q[1];
        db_cnt   <= '0;
        press    <= ~sync_q[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign pressed = ~stable_n;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step-enable source for the core: debounced single-step button or run-rate tick.
// Optional hold-to-repeat stepping is built when STEP_AUTOREPEAT_EN is defined.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RUN_DIV         = RUN_DIV_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int unsigned COUNT_W         = COUNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               step_button_n,
  input  logic               run_mode,
  input  logic               halt,
  output logic               step_en,
  output logic [COUNT_W-1:0] step_count,
  output logic               core_reset,
  output logic               run_active
);

  localparam int unsigned PS_W = cnt_w(RUN_DIV);

  step_mode_e      mode_q, mode_d;
  logic [1:0]      rst_sync_q;
  logic [1:0]      run_sync_q;
  logic            run_sync;
  logic [PS_W-1:0] presc_q;
  logic            tick;
  logic            press;
  logic            btn_pressed;
  logic            rep_step;
  logic            step_d;
  logic            step_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b11;
      run_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
      run_sync_q <= {run_sync_q[0], run_mode};
    end
  end

  assign core_reset = rst_sync_q[1];
  assign run_sync   = run_sync_q[1];

  step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (core_reset),
    .button_n (step_button_n),
    .pressed  (btn_pressed),
    .press    (press)
  );

  assign tick = (mode_q == MODE_RUN) && (presc_q == PS_W'(RUN_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if ((mode_q != MODE_RUN) || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RP_W = cnt_w(REPEAT_CYCLES);
  logic [RP_W-1:0] rep_q;

  assign rep_step = (mode_q == MODE_MANUAL) && btn_pressed && !press &&
                    (rep_q == RP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_q <= '0;
    end else if (core_reset || (mode_q != MODE_MANUAL) || !btn_pressed || press || rep_step) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end
`else
  // Held-button level and repeat interval only matter with autorepeat built in.
  logic unused_repeat;
  assign unused_repeat = btn_pressed ^ (REPEAT_CYCLES != 0);
  assign rep_step      = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    step_d = 1'b0;
    unique case (mode_q)
      MODE_MANUAL: begin
        step_d = press | rep_step;
        if (run_sync) mode_d = MODE_RUN;
      end
      MODE_RUN: begin
        if (!run_sync)  mode_d = MODE_MANUAL;
        else if (halt)  mode_d = MODE_HALTED;
        else            step_d = tick;
      end
      MODE_HALTED: begin
        if (!run_sync) mode_d = MODE_MANUAL;
      end
      default: mode_d = MODE_MANUAL;
    endcase
  end

  assign step_fire = step_d & ~core_reset;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_MANUAL;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      mode_q     <= mode_d;
      step_en    <= step_fire;
      step_count <= step_count + COUNT_W'(step_fire);
    end
  end

  assign run_active = (mode_q == MODE_RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected steps are queued as stimulus is driven.
module tb_cpu_step_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned REP = 16;
  localparam int unsigned CW  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          step_button_n = 1'b1;
  logic          run_mode = 1'b0;
  logic          halt = 1'b0;
  logic          step_en;
  logic [CW-1:0] step_count;
  logic          core_reset;
  logic          run_active;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .RUN_DIV         (DIV),
    .REPEAT_CYCLES   (REP),
    .COUNT_W         (CW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .step_button_n (step_button_n),
    .run_mode      (run_mode),
    .halt          (halt),
    .step_en       (step_en),
    .step_count    (step_count),
    .core_reset    (core_reset),
    .run_active    (run_active)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int cnt;
    int at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   model_cnt = 0;
  int   t0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_step(input int at);
    model_cnt = (model_cnt + 1) % (1 << CW);
    exp_q.push_back('{model_cnt, at});
  endtask

  task automatic do_press(input bit expect_it);
    if (expect_it) expect_step(-1);
    step_button_n = 1'b0;
    repeat (10) @(negedge clock);
    step_button_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_run(output int t);
    t = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (run_active) begin
        t = cyc;
        break;
      end
    end
    check("run_active_rise", int'(t >= 0), 1);
  endtask

  always @(negedge clock) begin
    if (reset_n && step_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", int'(step_en), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("step_count", int'(step_count), mon_e.cnt);
        if (mon_e.at >= 0) check("step_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset values and core_reset release timing
    repeat (3) @(negedge clock);
    check("rst_step_en", int'(step_en), 0);
    check("rst_step_count", int'(step_count), 0);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_run_active", int'(run_active), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("core_reset_edge1", int'(core_reset), 1);
    @(negedge clock);
    check("core_reset_edge2", int'(core_reset), 0);
    repeat (5) @(negedge clock);

    // Bouncing button: only the final steady hold produces a step
    for (int i = 0; i < 10; i++) begin
      step_button_n = i[0];
      repeat (2) @(negedge clock);
    end
    expect_step(-1);
    step_button_n = 1'b0;
    repeat (10) @(negedge clock);
    step_button_n = 1'b1;
    repeat (10) @(negedge clock);
    check("bounce_count", int'(step_count), 1);
    check("bounce_q", exp_q.size(), 0);

    // Free run: a step every DIV cycles, first one DIV cycles after entry
    run_mode = 1'b1;
    wait_run(t0);
    for (int k = 1; k <= 10; k++) expect_step(t0 + k * DIV);
    repeat (80) @(negedge clock);
    run_mode = 1'b0;
    repeat (10) @(negedge clock);
    check("run_q", exp_q.size(), 0);
    check("run_exit_active", int'(run_active), 0);

    // Halt on a tick cycle
    run_mode = 1'b1;
    wait_run(t0);
    expect_step(t0 + DIV);
    repeat (2 * DIV - 1) @(negedge clock);
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    check("halt_step_en", int'(step_en), 0);
    check("halt_run_active", int'(run_active), 0);
    repeat (20) @(negedge clock);
    do_press(1'b0);
    check("halted_run_active", int'(run_active), 0);
    run_mode = 1'b0;
    repeat (5) @(negedge clock);
    do_press(1'b1);
    check("halt_q", exp_q.size(), 0);
    check("halt_count", int'(step_count), model_cnt);

    // Counter wrap across 2^CW
    for (int i = 0; i < 17; i++) do_press(1'b1);
    check("wrap_count", int'(step_count), model_cnt);

    // Mid-operation reset with the button held
    run_mode = 1'b1;
    wait_run(t0);
    expect_step(t0 + DIV);
    repeat (DIV + 2) @(negedge clock);
    step_button_n = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_reset_q", exp_q.size(), 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_step_en", int'(step_en), 0);
    check("midrst_step_count", int'(step_count), 0);
    check("midrst_core_reset", int'(core_reset), 1);
    check("midrst_run_active", int'(run_active), 0);
    model_cnt = 0;
    run_mode  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("held_through_reset", int'(step_count), model_cnt);
    step_button_n = 1'b1;
    repeat (10) @(negedge clock);
    do_press(1'b1);
    check("repress_count", int'(step_count), model_cnt);

`ifdef STEP_AUTOREPEAT_EN
    // Hold-to-repeat: press plus two repeats within 40 cycles
    expect_step(-1);
    expect_step(-1);
    expect_step(-1);
    step_button_n = 1'b0;
    repeat (40) @(negedge clock);
    step_button_n = 1'b1;
    repeat (20) @(negedge clock);
    check("repeat_count", int'(step_count), model_cnt);
`endif

    repeat (5) @(negedge clock);
    check("final_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
